dm: RTL and testbench

Data memory for the single-cycle datapath, directly downstream of the ALU. The ALU result drives the byte address and the register-file rt value drives the store data. The block performs word, half and byte stores with byte enables, and sign- or zero-extending loads. It also flags misaligned and out-of-range accesses and latches the first faulting address for debug.

---
 rtl/dm_pkg.sv | 48 ++++
 rtl/dm_load_ext.sv | 28 ++
 rtl/dm.sv | 99 +++++++++
 tb/tb_dm.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings and byte-enable/alignment helpers for the data memory.
package dm_pkg;

    localparam logic [1:0] WSEL_WORD = 2'd0;
    localparam logic [1:0] WSEL_HALF = 2'd1;
    localparam logic [1:0] WSEL_BYTE = 2'd2;

    localparam logic [2:0] RSEL_LW  = 3'd0;
    localparam logic [2:0] RSEL_LH  = 3'd1;
    localparam logic [2:0] RSEL_LHU = 3'd2;
    localparam logic [2:0] RSEL_LB  = 3'd3;
    localparam logic [2:0] RSEL_LBU = 3'd4;

    function automatic logic [3:0] byte_en(input logic [1:0] wsel, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (wsel)
            WSEL_WORD: be = 4'b1111;
            WSEL_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            WSEL_BYTE: be = 4'b0001 << off;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic store_misaligned(input logic [1:0] wsel, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (wsel)
            WSEL_WORD: bad = (off != 2'b00);
            WSEL_HALF: bad = off[0];
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic load_misaligned(input logic [2:0] rsel, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (rsel)
            RSEL_LW:           bad = (off != 2'b00);
            RSEL_LH, RSEL_LHU: bad = off[0];
            default:           bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Picks the half/byte out of a stored word and sign- or zero-extends it.
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  rsel,
    output logic [31:0] data
);

    logic [15:0] half;
    logic [7:0]  byt;

    always_comb begin
        half = off[1] ? word[31:16] : word[15:0];
        byt  = word[8*off +: 8];
        data = 32'h0;
        case (rsel)
            RSEL_LW:  data = word;
            RSEL_LH:  data = {{16{half[15]}}, half};
            RSEL_LHU: data = {16'h0, half};
            RSEL_LB:  data = {{24{byt[7]}}, byt};
            RSEL_LBU: data = {24'h0, byt};
            default:  data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dm.sv
// Byte-addressable data memory with combinational loads, masked stores and
// a sticky record of the first faulting address.
module dm
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [1:0]  wsel,
    input  logic        re,
    input  logic [2:0]  rsel,
    output logic [31:0] rdata,
    output logic        align_err,
    output logic        range_err,
    output logic        err_sticky,
    output logic [31:0] fault_addr
);

    localparam int IW    = ADDR_WIDTH - 2;
    localparam int WORDS = 1 << IW;

    logic [31:0]   mem [WORDS];
    logic [IW-1:0] idx;
    logic [1:0]    off;
    logic          err;
    logic          wr_en;
    logic [3:0]    be;
    logic [31:0]   lane;
    logic [31:0]   old_word;
    logic [31:0]   new_word;
    logic [31:0]   ext_data;

    assign idx      = addr[ADDR_WIDTH-1:2];
    assign off      = addr[1:0];
    assign old_word = mem[idx];
    assign be       = byte_en(wsel, off);

    // Anything above the decoded window is out of range; no aliasing.
    assign range_err = ((addr >> ADDR_WIDTH) != 32'h0);

    always_comb begin
        align_err = 1'b0;
        if (we)
            align_err = store_misaligned(wsel, off);
        else if (re)
            align_err = load_misaligned(rsel, off);
    end

    assign err   = align_err | range_err;
    assign wr_en = we & ~err;

    always_comb begin
        lane = wdata;
        case (wsel)
            WSEL_HALF: lane = {2{wdata[15:0]}};
            WSEL_BYTE: lane = {4{wdata[7:0]}};
            default:   lane = wdata;
        endcase
        new_word = old_word;
        for (int b = 0; b < 4; b++)
            if (be[b])
                new_word[8*b +: 8] = lane[8*b +: 8];
    end

    for (genvar w = 0; w < WORDS; w++) begin : g_word
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                mem[w] <= 32'h0;
            else if (wr_en && (idx == IW'(w)))
                mem[w] <= new_word;
        end
    end

    dm_load_ext u_ext (
        .word (old_word),
        .off  (off),
        .rsel (rsel),
        .data (ext_data)
    );

    assign rdata = err ? 32'h0 : ext_data;

    // First fault wins: the address is captured only while the flag is clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sticky <= 1'b0;
            fault_addr <= 32'h0;
        end else if ((we | re) & err) begin
            err_sticky <= 1'b1;
            if (!err_sticky)
                fault_addr <= addr;
        end
    end

endmodule

// File: tb/tb_dm.sv
// Directed-vector bench for dm: table of single-cycle accesses plus an
// asynchronous-reset-during-store sequence.
module tb_dm;
    import dm_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  wsel;
        logic        re;
        logic [2:0]  rsel;
        logic [31:0] exp_rdata;
        logic        exp_align;
        logic        exp_range;
        logic        exp_sticky;
        logic [31:0] exp_fault;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  wsel;
    logic        re;
    logic [2:0]  rsel;
    logic [31:0] rdata;
    logic        align_err;
    logic        range_err;
    logic        err_sticky;
    logic [31:0] fault_addr;

    int total_checks;
    int passed_checks;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    dm #(.ADDR_WIDTH(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .wdata      (wdata),
        .we         (we),
        .wsel       (wsel),
        .re         (re),
        .rsel       (rsel),
        .rdata      (rdata),
        .align_err  (align_err),
        .range_err  (range_err),
        .err_sticky (err_sticky),
        .fault_addr (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic [31:0] a, logic [31:0] d, logic w,
                                logic [1:0] ws, logic r, logic [2:0] rs,
                                logic [31:0] erd, logic eal, logic erg,
                                logic est, logic [31:0] efa);
        vec_t v;
        v.name = n; v.addr = a; v.wdata = d; v.we = w; v.wsel = ws;
        v.re = r; v.rsel = rs; v.exp_rdata = erd; v.exp_align = eal;
        v.exp_range = erg; v.exp_sticky = est; v.exp_fault = efa;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        addr  = v.addr;
        wdata = v.wdata;
        we    = v.we;
        wsel  = v.wsel;
        re    = v.re;
        rsel  = v.rsel;
    endtask

    task automatic checkOutput(input string n, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", n, actual, expected);
        else
            passed_checks++;
    endtask

    task automatic checkLoad(input string n, input logic [31:0] a, input logic [31:0] expected);
        @(negedge clk);
        addr = a; we = 1'b0; re = 1'b1; rsel = RSEL_LW; wsel = WSEL_WORD; wdata = 32'h0;
        #1;
        checkOutput(n, rdata, expected);
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;

        vecs[0]  = mk("lw_0x0",        32'h0,    32'h0,        1'b0, WSEL_WORD, 1'b1, RSEL_LW,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0);
        vecs[1]  = mk("lw_0xffc",      32'hFFC,  32'h0,        1'b0, WSEL_WORD, 1'b1, RSEL_LW,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0);
        vecs[2]  = mk("sw_0x10",       32'h10,   32'h12345678, 1'b1, WSEL_WORD, 1'b0, RSEL_LW,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0);
        vecs[3]  = mk("lb_0x13",       32'h13,   32'h0,        1'b0, WSEL_WORD, 1'b1, RSEL_LB,  32'h00000012, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[4]  = mk("lh_0x12",       32'h12,   32'h0,        1'b0, WSEL_WORD, 1'b1, RSEL_LH,  32'h00001234, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[5]  = mk("lbu_0x10",      32'h10,   32'h0,        1'b0, WSEL_WORD, 1'b1, RSEL_LBU, 32'h00000078, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[6]  = mk("sw_0x20",       32'h20,   32'hFFFF8080, 1'b1, WSEL_WORD, 1'b0, RSEL_LW,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0);
        vecs[7]  = mk("lb_0x20",       32'h20,   32'h0,        1'b0, WSEL_WORD, 1'b1, RSEL_LB,  32'hFFFFFF80, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[8]  = mk("lhu_0x20",      32'h20,   32'h0,        1'b0, WSEL_WORD, 1'b1, RSEL_LHU, 32'h00008080, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[9]  = mk("lh_0x22",       32'h22,   32'h0,        1'b0, WSEL_WORD, 1'b1, RSEL_LH,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[10] = mk("sw0_0x30",      32'h30,   32'h0,        1'b1, WSEL_WORD, 1'b0, RSEL_LW,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0);
        vecs[11] = mk("sb_0x31",       32'h31,   32'h000000AB, 1'b1, WSEL_BYTE, 1'b0, RSEL_LW,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0);
        vecs[12] = mk("sh_0x32_rd",    32'h32,   32'h0000CDEF, 1'b1, WSEL_HALF, 1'b1, RSEL_LW,  32'h0000AB00, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[13] = mk("lw_0x30",       32'h30,   32'h0,        1'b0, WSEL_WORD, 1'b1, RSEL_LW,  32'hCDEFAB00, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[14] = mk("wsel3_0x10",    32'h10,   32'hFFFFFFFF, 1'b1, 2'd3,      1'b0, RSEL_LW,  32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[15] = mk("lw_0x10_keep",  32'h10,   32'h0,        1'b0, WSEL_WORD, 1'b1, RSEL_LW,  32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[16] = mk("rsel5_0x10",    32'h10,   32'h0,        1'b0, WSEL_WORD, 1'b1, 3'd5,     32'h0,        1'b0, 1'b0, 1'b0, 32'h0);
        vecs[17] = mk("sw_mis_0x42",   32'h42,   32'hDEADBEEF, 1'b1, WSEL_WORD, 1'b0, RSEL_LW,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0);
        vecs[18] = mk("lw_0x40",       32'h40,   32'h0,        1'b0, WSEL_WORD, 1'b1, RSEL_LW,  32'h0,        1'b0, 1'b0, 1'b1, 32'h42);
        vecs[19] = mk("lw_0x2000",     32'h2000, 32'h0,        1'b0, WSEL_WORD, 1'b1, RSEL_LW,  32'h0,        1'b0, 1'b1, 1'b1, 32'h42);
        vecs[20] = mk("lh_mis_0x11",   32'h11,   32'h0,        1'b0, WSEL_WORD, 1'b1, RSEL_LH,  32'h0,        1'b1, 1'b0, 1'b1, 32'h42);
        vecs[21] = mk("lb_0xfff",      32'hFFF,  32'h0,        1'b0, WSEL_WORD, 1'b1, RSEL_LB,  32'h0,        1'b0, 1'b0, 1'b1, 32'h42);
        vecs[22] = mk("lw_0x1000",     32'h1000, 32'h0,        1'b0, WSEL_WORD, 1'b0, RSEL_LW,  32'h0,        1'b0, 1'b1, 1'b1, 32'h42);
        vecs[23] = mk("sb_0x1003",     32'h1003, 32'h00000011, 1'b1, WSEL_BYTE, 1'b0, RSEL_LW,  32'h0,        1'b0, 1'b1, 1'b1, 32'h42);
        vecs[24] = mk("lw_0x0_noalias",32'h0,    32'h0,        1'b0, WSEL_WORD, 1'b1, RSEL_LW,  32'h0,        1'b0, 1'b0, 1'b1, 32'h42);

        reset = 1'b1;
        addr = 32'h0; wdata = 32'h0; we = 1'b0; wsel = WSEL_WORD; re = 1'b0; rsel = RSEL_LW;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput({vecs[i].name, ".rdata"},  rdata,               vecs[i].exp_rdata);
            checkOutput({vecs[i].name, ".align"},  {31'h0, align_err},  {31'h0, vecs[i].exp_align});
            checkOutput({vecs[i].name, ".range"},  {31'h0, range_err},  {31'h0, vecs[i].exp_range});
            checkOutput({vecs[i].name, ".sticky"}, {31'h0, err_sticky}, {31'h0, vecs[i].exp_sticky});
            checkOutput({vecs[i].name, ".fault"},  fault_addr,          vecs[i].exp_fault);
        end

        // Reset lands mid-cycle while a store is pending and spans the edge.
        @(negedge clk);
        addr = 32'h10; wdata = 32'h00000055; we = 1'b1; wsel = WSEL_WORD; re = 1'b0; rsel = RSEL_LW;
        #2 reset = 1'b1;
        #1;
        checkOutput("rst.rdata_during", rdata, 32'h0);
        checkOutput("rst.sticky", {31'h0, err_sticky}, 32'h0);
        checkOutput("rst.fault", fault_addr, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        we    = 1'b0;
        checkLoad("rst.lw_0x10", 32'h10, 32'h0);
        checkLoad("rst.lw_0x20", 32'h20, 32'h0);
        checkLoad("rst.lw_0x30", 32'h30, 32'h0);
        #1;
        checkOutput("rst.sticky_after", {31'h0, err_sticky}, 32'h0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
